// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: owner states,
// default starvation/burst limits and the word-alignment helper.
package dm_port_arbiter_pkg;

    typedef enum logic {
        ARB_S_CPU = 1'b0,
        ARB_S_DMA = 1'b1
    } arb_state_e;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;
    localparam int unsigned BURST_MAX_DEFAULT    = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU MEM-stage, DMA requester and physical DM signals around
// the arbiter; master is the surrounding system, slave is the arbiter.
interface dm_port_arbiter_if;

    logic        cpu_req;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_valid;
    logic        dma_ready;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_we;
    logic        dma_last;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic [31:0] dm_pc;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_we;
    logic [31:0] dm_rdata;

    modport master (
        output cpu_req, cpu_pc, cpu_addr, cpu_wdata, cpu_we,
        input  cpu_rdata, cpu_stall,
        output dma_valid, dma_addr, dma_wdata, dma_we, dma_last,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  dm_pc, dm_addr, dm_wdata, dm_we,
        output dm_rdata
    );

    modport slave (
        input  cpu_req, cpu_pc, cpu_addr, cpu_wdata, cpu_we,
        output cpu_rdata, cpu_stall,
        input  dma_valid, dma_addr, dma_wdata, dma_we, dma_last,
        output dma_ready, dma_rvalid, dma_rdata,
        output dm_pc, dm_addr, dm_wdata, dm_we,
        input  dm_rdata
    );

endinterface

// File: rtl/dm_port_arbiter_fsm.sv
// Ownership FSM: tracks how long DMA has been blocked by the CPU and runs a
// bounded forced DMA burst once the starvation limit is hit.
module dm_port_arbiter_fsm
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned BURST_MAX    = BURST_MAX_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_valid,
    input  logic dma_last,
    output logic owner_dma,
    output logic in_burst
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_MAX + 1);
    // Comparing against limit-1 means neither counter ever holds its limit.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    arb_state_e        state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [BEAT_W-1:0] beat_cnt, beat_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_S_CPU;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            beat_cnt <= beat_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave a value held (no latch inferred).
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        beat_next  = beat_cnt;
        owner_dma  = 1'b0;
        unique case (state)
            ARB_S_CPU: begin
                owner_dma = dma_valid & ~cpu_req;
                if (dma_valid && cpu_req) begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_next  = '0;
                        state_next = ARB_S_DMA;
                    end else begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    wait_next = '0;
                end
            end
            ARB_S_DMA: begin
                owner_dma = 1'b1;
                wait_next = '0;
                // An idle DMA cycle ends the burst as well as last/limit beats.
                if (!dma_valid || dma_last || beat_cnt == BEAT_LAST) begin
                    state_next = ARB_S_CPU;
                    beat_next  = '0;
                end else begin
                    beat_next = beat_cnt + BEAT_W'(1);
                end
            end
        endcase
    end

    assign in_burst = (state == ARB_S_DMA);

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: muxes the CPU MEM stage or the DMA requester onto
// the single DM port, stalls the pipeline during forced DMA bursts.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned BURST_MAX    = BURST_MAX_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    dm_port_arbiter_if.slave bus
);

    logic owner_dma;
    logic in_burst;
    logic rd_accept;

    dm_port_arbiter_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .BURST_MAX    (BURST_MAX)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (bus.cpu_req),
        .dma_valid (bus.dma_valid),
        .dma_last  (bus.dma_last),
        .owner_dma (owner_dma),
        .in_burst  (in_burst)
    );

    // A port with no active requester drives all zeros, so no stray writes.
    always_comb begin
        bus.dm_pc    = '0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_we    = '0;
        if (owner_dma) begin
            bus.dm_addr  = word_align(bus.dma_addr);
            bus.dm_wdata = bus.dma_wdata;
            bus.dm_we    = bus.dma_valid ? bus.dma_we : 4'h0;
        end else if (bus.cpu_req) begin
            bus.dm_pc    = bus.cpu_pc;
            bus.dm_addr  = word_align(bus.cpu_addr);
            bus.dm_wdata = bus.cpu_wdata;
            bus.dm_we    = bus.cpu_we;
        end
    end

    assign bus.dma_ready = owner_dma & bus.dma_valid;
    assign bus.cpu_stall = in_burst & bus.cpu_req;
    assign bus.cpu_rdata = bus.dm_rdata;
    assign rd_accept     = bus.dma_ready & (bus.dma_we == 4'h0);

    // NOTE: the read-data register is reset too so the DMA side never sees
    // X data after reset, even though dma_rvalid alone qualifies it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= '0;
        end else begin
            bus.dma_rvalid <= rd_accept;
            if (rd_accept) begin
                bus.dma_rdata <= bus.dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed scoreboard bench for dm_port_arbiter: slot steal, forced bursts,
// early dma_last exit, CPU store during a burst and reset mid-burst.
module tb_dm_port_arbiter;

    typedef struct packed {
        logic        cpu_req;
        logic [31:0] cpu_pc;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic [3:0]  cpu_we;
        logic        dma_valid;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic [3:0]  dma_we;
        logic        dma_last;
    } stim_t;

    typedef struct packed {
        logic        ready;
        logic        stall;
        logic        rvalid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    exp_t        cycle_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem [256];

    dm_port_arbiter_if bus ();

    dm_port_arbiter #(
        .STARVE_LIMIT (8),
        .BURST_MAX    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical DM model: combinational read, byte-enabled write at the edge.
    assign bus.dm_rdata = mem[bus.dm_addr[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | 32'(i);
        forever begin
            @(posedge clk);
            for (int b = 0; b < 4; b++) begin
                if (bus.dm_we[b]) mem[bus.dm_addr[9:2]][8*b +: 8] = bus.dm_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t st(input logic cr, input logic [31:0] pc, input logic [31:0] ca,
                                 input logic [31:0] cw, input logic [3:0] cwe, input logic dv,
                                 input logic [31:0] da, input logic [31:0] dw,
                                 input logic [3:0] dwe, input logic dl);
        return '{cr, pc, ca, cw, cwe, dv, da, dw, dwe, dl};
    endfunction

    function automatic exp_t ex(input logic rdy, input logic stl, input logic rv,
                                input logic [31:0] pc, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] we);
        return '{rdy, stl, rv, pc, addr, wd, we, 1'b0, 32'h0};
    endfunction

    task automatic drive(input stim_t s);
        bus.cpu_req   = s.cpu_req;
        bus.cpu_pc    = s.cpu_pc;
        bus.cpu_addr  = s.cpu_addr;
        bus.cpu_wdata = s.cpu_wdata;
        bus.cpu_we    = s.cpu_we;
        bus.dma_valid = s.dma_valid;
        bus.dma_addr  = s.dma_addr;
        bus.dma_wdata = s.dma_wdata;
        bus.dma_we    = s.dma_we;
        bus.dma_last  = s.dma_last;
    endtask

    task automatic cyc(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        drive(s);
        cycle_q.push_back(e);
    endtask

    // Monitor: compares the cycle's expected port state and pops read data
    // whenever the DUT presents dma_rvalid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cycle_q.size() > 0) begin
                e = cycle_q.pop_front();
                check("dma_ready", 32'(bus.dma_ready), 32'(e.ready));
                check("cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
                check("dma_rvalid", 32'(bus.dma_rvalid), 32'(e.rvalid));
                check("dm_pc", bus.dm_pc, e.pc);
                check("dm_addr", bus.dm_addr, e.addr);
                check("dm_wdata", bus.dm_wdata, e.wdata);
                check("dm_we", 32'(bus.dm_we), 32'(e.we));
                if (e.chk_rd) check("cpu_rdata_value", bus.cpu_rdata, e.rdata);
                else          check("cpu_rdata_passthru", bus.cpu_rdata, bus.dm_rdata);
            end
            if (bus.dma_rvalid) begin
                if (rd_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
                else                  check("dma_rdata", bus.dma_rdata, rd_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t idle_s;
        exp_t  zero_e;
        exp_t  e;
        idle_s       = '0;
        zero_e       = '0;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(idle_s);

        // Reset held for 3 cycles, then one idle cycle out of reset.
        for (int i = 0; i < 3; i++) cyc(idle_s, zero_e);
        reset = 1'b1;
        cyc(idle_s, zero_e);

        // Slot steal read of 0x104, byte-enabled write to 0x10A, read-back.
        cyc(st(1'b0, '0, '0, '0, 4'h0, 1'b1, 32'h104, '0, 4'h0, 1'b1),
            ex(1'b1, 1'b0, 1'b0, '0, 32'h104, '0, 4'h0));
        rd_q.push_back(32'hD000_0041);
        cyc(idle_s, ex(1'b0, 1'b0, 1'b1, '0, '0, '0, 4'h0));
        cyc(st(1'b0, '0, '0, '0, 4'h0, 1'b1, 32'h10A, 32'hBEEF_0001, 4'h3, 1'b1),
            ex(1'b1, 1'b0, 1'b0, '0, 32'h108, 32'hBEEF_0001, 4'h3));
        cyc(idle_s, zero_e);
        cyc(st(1'b0, '0, '0, '0, 4'h0, 1'b1, 32'h108, '0, 4'h0, 1'b1),
            ex(1'b1, 1'b0, 1'b0, '0, 32'h108, '0, 4'h0));
        rd_q.push_back(32'hD000_0001);
        cyc(idle_s, ex(1'b0, 1'b0, 1'b1, '0, '0, '0, 4'h0));

        // Starvation: 8 blocked cycles, 4 forced write beats, CPU back on 13.
        for (int i = 0; i < 8; i++)
            cyc(st(1'b1, 32'h1000, 32'h303, '0, 4'h0, 1'b1, 32'h200, 32'h1111_0000, 4'hF, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 32'h1000, 32'h300, '0, 4'h0));
        for (int k = 0; k < 4; k++)
            cyc(st(1'b1, 32'h1000, 32'h303, '0, 4'h0, 1'b1, 32'h200 + 32'(4*k),
                   32'h1111_0000 + 32'(k), 4'hF, 1'b0),
                ex(1'b1, 1'b1, 1'b0, '0, 32'h200 + 32'(4*k), 32'h1111_0000 + 32'(k), 4'hF));
        cyc(st(1'b1, 32'h1000, 32'h303, '0, 4'h0, 1'b1, 32'h210, 32'h1111_0004, 4'hF, 1'b0),
            ex(1'b0, 1'b0, 1'b0, 32'h1000, 32'h300, '0, 4'h0));
        cyc(idle_s, zero_e);
        cyc(st(1'b0, '0, '0, '0, 4'h0, 1'b1, 32'h20C, '0, 4'h0, 1'b1),
            ex(1'b1, 1'b0, 1'b0, '0, 32'h20C, '0, 4'h0));
        rd_q.push_back(32'h1111_0003);
        cyc(idle_s, ex(1'b0, 1'b0, 1'b1, '0, '0, '0, 4'h0));

        // Forced burst of reads ended by dma_last on beat 2.
        for (int i = 0; i < 8; i++)
            cyc(st(1'b1, 32'h2000, 32'h303, '0, 4'h0, 1'b1, 32'h104, '0, 4'h0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 32'h2000, 32'h300, '0, 4'h0));
        cyc(st(1'b1, 32'h2000, 32'h303, '0, 4'h0, 1'b1, 32'h104, '0, 4'h0, 1'b0),
            ex(1'b1, 1'b1, 1'b0, '0, 32'h104, '0, 4'h0));
        rd_q.push_back(32'hD000_0041);
        cyc(st(1'b1, 32'h2000, 32'h303, '0, 4'h0, 1'b1, 32'h108, '0, 4'h0, 1'b1),
            ex(1'b1, 1'b1, 1'b1, '0, 32'h108, '0, 4'h0));
        rd_q.push_back(32'hD000_0001);
        cyc(st(1'b1, 32'h2000, 32'h303, '0, 4'h0, 1'b0, '0, '0, 4'h0, 1'b0),
            ex(1'b0, 1'b0, 1'b1, 32'h2000, 32'h300, '0, 4'h0));
        cyc(idle_s, zero_e);

        // CPU store held off by a DMA write to the same word.
        for (int i = 0; i < 8; i++)
            cyc(st(1'b1, 32'h3000, 32'h303, '0, 4'h0, 1'b1, 32'h200, 32'h5555_5555, 4'hF, 1'b1),
                ex(1'b0, 1'b0, 1'b0, 32'h3000, 32'h300, '0, 4'h0));
        cyc(st(1'b1, 32'h3004, 32'h200, 32'hCCCC_CCCC, 4'hF, 1'b1, 32'h200, 32'h5555_5555, 4'hF, 1'b1),
            ex(1'b1, 1'b1, 1'b0, '0, 32'h200, 32'h5555_5555, 4'hF));
        e        = ex(1'b0, 1'b0, 1'b0, 32'h3004, 32'h200, 32'hCCCC_CCCC, 4'hF);
        e.chk_rd = 1'b1;
        e.rdata  = 32'h5555_5555;
        cyc(st(1'b1, 32'h3004, 32'h200, 32'hCCCC_CCCC, 4'hF, 1'b0, '0, '0, 4'h0, 1'b0), e);
        cyc(idle_s, zero_e);
        cyc(st(1'b0, '0, '0, '0, 4'h0, 1'b1, 32'h200, '0, 4'h0, 1'b1),
            ex(1'b1, 1'b0, 1'b0, '0, 32'h200, '0, 4'h0));
        rd_q.push_back(32'hCCCC_CCCC);
        cyc(idle_s, ex(1'b0, 1'b0, 1'b1, '0, '0, '0, 4'h0));

        // Reset asserted during beat 2 of a forced read burst.
        for (int i = 0; i < 8; i++)
            cyc(st(1'b1, 32'h4000, 32'h303, '0, 4'h0, 1'b1, 32'h104, '0, 4'h0, 1'b0),
                ex(1'b0, 1'b0, 1'b0, 32'h4000, 32'h300, '0, 4'h0));
        cyc(st(1'b1, 32'h4000, 32'h303, '0, 4'h0, 1'b1, 32'h104, '0, 4'h0, 1'b0),
            ex(1'b1, 1'b1, 1'b0, '0, 32'h104, '0, 4'h0));
        rd_q.push_back(32'hD000_0041);
        cyc(st(1'b1, 32'h4000, 32'h303, '0, 4'h0, 1'b1, 32'h108, '0, 4'h0, 1'b0),
            ex(1'b1, 1'b1, 1'b1, '0, 32'h108, '0, 4'h0));
        @(negedge clk);
        #1;
        reset = 1'b0;
        cyc(st(1'b1, 32'h4000, 32'h303, '0, 4'h0, 1'b1, 32'h10C, '0, 4'h0, 1'b0),
            ex(1'b0, 1'b0, 1'b0, 32'h4000, 32'h300, '0, 4'h0));
        reset = 1'b1;
        cyc(st(1'b1, 32'h4000, 32'h303, '0, 4'h0, 1'b1, 32'h10C, '0, 4'h0, 1'b0),
            ex(1'b0, 1'b0, 1'b0, 32'h4000, 32'h300, '0, 4'h0));
        cyc(idle_s, zero_e);
        cyc(idle_s, zero_e);

        @(negedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("cycle_q_drained", 32'(cycle_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
